// File: rtl/mem_pkg.sv
// Shared definitions for the MAR/MDR memory responder: bus width,
// FSM state encoding and latched operation encoding.
package mem_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2,
    HOLD = 2'd3
  } state_e;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_e;

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous word RAM. Storage has no reset; only the read
// register is cleared so the MDR-facing data starts at zero.
module mem_array #(
  parameter int WORD_W = 32,
  parameter int ADDR_W = 9,
  parameter int DEPTH  = 512
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] din,
  output logic [WORD_W-1:0] dout
);

  logic [WORD_W-1:0] mem_r [DEPTH];

  // Storage write port, qualified by the access enable.
  always_ff @(posedge clock) begin
    if (en && we) begin
      mem_r[addr] <= din;
    end
  end

  // Read register: only a completed read updates it, so it holds between reads.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      dout <= '0;
    end else if (en && !we) begin
      dout <= mem_r[addr];
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Memory responder behind MAR/MDR: accepts one Read or Write level,
// waits WAIT_STATES cycles, performs the access and strobes done.
module mem_responder #(
  parameter int WORD_W      = mem_pkg::WORD_W,
  parameter int ADDR_W      = 9,
  parameter int DEPTH       = 512,
  parameter int WAIT_STATES = 2
) (
  input  logic              clock,
  input  logic              clear,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  input  logic              read,
  input  logic              write,
  output logic [WORD_W-1:0] rdata,
  output logic              done,
  output logic              err,
  output logic              busy
);

  import mem_pkg::*;

  localparam logic [3:0] WAIT_C = 4'(WAIT_STATES);

  state_e            state_r;
  op_e               op_r;
  logic [3:0]        cnt_r;
  logic [ADDR_W-1:0] addr_r;
  logic [WORD_W-1:0] wdata_r;
  logic              done_r;
  logic              err_r;
  logic              busy_r;
  logic              acc_s;
  logic              we_s;

  assign done = done_r;
  assign err  = err_r;
  assign busy = busy_r;

  // Access fires on the edge where BUSY has exhausted its wait count.
  always_comb begin
    acc_s = 1'b0;
    we_s  = 1'b0;
    if ((state_r == BUSY) && (cnt_r == 4'd0)) begin
      acc_s = 1'b1;
    end else begin
      acc_s = 1'b0;
    end
    if (op_r == OP_WR) begin
      we_s = 1'b1;
    end else begin
      we_s = 1'b0;
    end
  end

  mem_array #(
    .WORD_W (WORD_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clock (clock),
    .clear (clear),
    .en    (acc_s),
    .we    (we_s),
    .addr  (addr_r),
    .din   (wdata_r),
    .dout  (rdata)
  );

  // Request FSM with wait counter, latched operands and registered strobes.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_r <= IDLE;
      op_r    <= OP_RD;
      cnt_r   <= 4'd0;
      addr_r  <= '0;
      wdata_r <= '0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      err_r  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (read ^ write) begin
            op_r    <= write ? OP_WR : OP_RD;
            addr_r  <= addr;
            wdata_r <= wdata;
            cnt_r   <= WAIT_C;
            state_r <= BUSY;
            busy_r  <= 1'b1;
          end else if (read && write) begin
            err_r   <= 1'b1;
            state_r <= HOLD;
          end else begin
            state_r <= IDLE;
          end
        end
        BUSY: begin
          if (cnt_r != 4'd0) begin
            cnt_r <= cnt_r - 4'd1;
          end else begin
            done_r  <= 1'b1;
            state_r <= DONE;
          end
        end
        DONE: begin
          busy_r  <= 1'b0;
          state_r <= HOLD;
        end
        HOLD: begin
          // A held Read/Write level must drop before another request is taken.
          if (!read && !write) begin
            state_r <= IDLE;
          end else begin
            state_r <= HOLD;
          end
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed scoreboard bench for mem_responder: one instance with two wait
// states and one with zero wait states.
module tb_mem_responder;
  import mem_pkg::*;

  localparam int WS = 2;

  logic        clock = 1'b0;
  logic        clear, clear0;
  logic        read, write, read0, write0;
  logic [8:0]  addr, addr0;
  logic [31:0] wdata, wdata0;
  logic [31:0] rdata, rdata0;
  logic        done, err, busy, done0, err0, busy0;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  int done_cnt0 = 0;
  int err_cnt = 0;

  logic [31:0] sb [$];
  logic [31:0] sb0 [$];
  logic [31:0] exp_rd, exp_rd0;
  logic [31:0] model [512];
  logic [31:0] model0 [512];

  mem_responder #(.WORD_W(32), .ADDR_W(9), .DEPTH(512), .WAIT_STATES(WS)) dut (
    .clock(clock), .clear(clear), .addr(addr), .wdata(wdata), .read(read),
    .write(write), .rdata(rdata), .done(done), .err(err), .busy(busy)
  );

  mem_responder #(.WORD_W(32), .ADDR_W(9), .DEPTH(512), .WAIT_STATES(0)) dut0 (
    .clock(clock), .clear(clear0), .addr(addr0), .wdata(wdata0), .read(read0),
    .write(write0), .rdata(rdata0), .done(done0), .err(err0), .busy(busy0)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Scoreboard for the WAIT_STATES=2 instance: every done pops one expectation.
  always @(negedge clock) begin
    if (done) begin
      done_cnt++;
      check("sb_nonempty", {31'd0, sb.size() != 0}, 32'd1);
      if (sb.size() != 0) check("rdata", rdata, sb.pop_front());
    end
    if (err) err_cnt++;
    if (done || err) check("strobe_excl", {31'd0, done & err}, 32'd0);
  end

  // Scoreboard for the WAIT_STATES=0 instance.
  always @(negedge clock) begin
    if (done0) begin
      done_cnt0++;
      check("sb0_nonempty", {31'd0, sb0.size() != 0}, 32'd1);
      if (sb0.size() != 0) check("rdata0", rdata0, sb0.pop_front());
    end
  end

  // One full transaction; a_late replaces addr (and wdata is inverted) after acceptance.
  task automatic txn(input int which, input logic is_wr, input logic [8:0] a,
                     input logic [8:0] a_late, input logic [31:0] d, input int ws);
    int n;
    int nb;
    logic cur_done, cur_busy;
    if (which == 0) begin
      if (!is_wr) exp_rd = model[a];
      sb.push_back(exp_rd);
      if (is_wr) model[a] = d;
      read = !is_wr; write = is_wr; addr = a; wdata = d;
    end else begin
      if (!is_wr) exp_rd0 = model0[a];
      sb0.push_back(exp_rd0);
      if (is_wr) model0[a] = d;
      read0 = !is_wr; write0 = is_wr; addr0 = a; wdata0 = d;
    end
    tick();
    if (which == 0) begin addr = a_late; wdata = ~d; end
    else begin addr0 = a_late; wdata0 = ~d; end
    n = 0;
    nb = 0;
    while (n < 20) begin
      cur_done = (which == 0) ? done : done0;
      cur_busy = (which == 0) ? busy : busy0;
      if (cur_busy) nb++;
      if (cur_done) break;
      tick();
      n++;
    end
    check("latency", n, ws + 1);
    check("busy_cycles", nb, ws + 2);
    if (which == 0) begin read = 1'b0; write = 1'b0; end
    else begin read0 = 1'b0; write0 = 1'b0; end
    tick();
    tick();
  endtask

  initial begin
    int d0;
    int e0;
    clear = 1'b1; clear0 = 1'b1;
    read = 1'b0; write = 1'b0; addr = 9'h000; wdata = 32'h0;
    read0 = 1'b0; write0 = 1'b0; addr0 = 9'h000; wdata0 = 32'h0;
    exp_rd = 32'h0; exp_rd0 = 32'h0;
    tick();
    tick();
    clear = 1'b0; clear0 = 1'b0;
    tick();
    check("rst_rdata", rdata, 32'h0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_state", 32'(dut.state_r), 32'(IDLE));
    check("rst_rdata0", rdata0, 32'h0);

    // Write then read with two wait states
    txn(0, 1'b1, 9'h010, 9'h010, 32'hDEADBEEF, WS);
    txn(0, 1'b0, 9'h010, 9'h010, 32'h0, WS);
    check("rdata_after_read", rdata, 32'hDEADBEEF);

    // Held Read level issues exactly once
    d0 = done_cnt;
    sb.push_back(model[9'h010]);
    read = 1'b1; addr = 9'h010;
    repeat (10) tick();
    check("held_done_count", done_cnt - d0, 1);
    check("held_state", 32'(dut.state_r), 32'(HOLD));
    check("held_busy", {31'd0, busy}, 32'd0);
    read = 1'b0;
    tick();
    check("held_release", 32'(dut.state_r), 32'(IDLE));

    // Simultaneous Read and Write is rejected
    txn(0, 1'b1, 9'h020, 9'h020, 32'hCAFEF00D, WS);
    d0 = done_cnt;
    e0 = err_cnt;
    read = 1'b1; write = 1'b1; addr = 9'h020; wdata = 32'h12345678;
    tick();
    check("err_strobe", {31'd0, err}, 32'd1);
    check("err_no_done", {31'd0, done}, 32'd0);
    tick();
    check("err_one_cycle", {31'd0, err}, 32'd0);
    read = 1'b0; write = 1'b0;
    tick();
    check("err_count", err_cnt - e0, 1);
    check("err_done_count", done_cnt - d0, 0);
    check("err_rdata_kept", rdata, exp_rd);
    txn(0, 1'b0, 9'h020, 9'h020, 32'h0, WS);

    // Clear in BUSY aborts the write
    txn(0, 1'b1, 9'h030, 9'h030, 32'hA5A5A5A5, WS);
    d0 = done_cnt;
    write = 1'b1; addr = 9'h030; wdata = 32'h0;
    tick();
    tick();
    clear = 1'b1;
    #1;
    check("clr_rdata", rdata, 32'h0);
    check("clr_done", {31'd0, done}, 32'd0);
    check("clr_err", {31'd0, err}, 32'd0);
    check("clr_busy", {31'd0, busy}, 32'd0);
    sb.delete();
    exp_rd = 32'h0;
    write = 1'b0;
    clear = 1'b0;
    tick();
    tick();
    check("clr_no_done", done_cnt - d0, 0);
    txn(0, 1'b0, 9'h030, 9'h030, 32'h0, WS);

    // Operands latched at acceptance
    txn(0, 1'b1, 9'h001, 9'h001, 32'h00000011, WS);
    txn(0, 1'b1, 9'h002, 9'h002, 32'h00000022, WS);
    txn(0, 1'b0, 9'h001, 9'h002, 32'h0, WS);
    check("latched_rdata", rdata, 32'h00000011);

    // Zero wait states at both address extremes
    txn(1, 1'b1, 9'h1FF, 9'h1FF, 32'h89ABCDEF, 0);
    txn(1, 1'b1, 9'h000, 9'h000, 32'h01234567, 0);
    txn(1, 1'b0, 9'h1FF, 9'h1FF, 32'h0, 0);
    txn(1, 1'b0, 9'h000, 9'h000, 32'h0, 0);
    check("ws0_done_count", done_cnt0, 4);
    check("ws0_rdata_final", rdata0, 32'h01234567);

    check("sb_drained", sb.size(), 0);
    check("sb0_drained", sb0.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
